raw10_pixel_unpacker: RTL and testbench

- Sits directly downstream of the CSI-2 packet receiver in the clock_p domain.
- Consumes 4-byte long-packet payload words (image_data[3:0] / image_data_enable / image_data_type) and the line/frame markers.
- Unpacks MIPI RAW10 (data type 0x2B: 4 pixels per 5 bytes) into 4-pixel, 10-bit groups with x/y coordinates for the ISP/framebuffer writer.

---
 rtl/raw10_pixel_unpacker.sv | 173 +++++++++++++++++
 tb/tb_raw10_pixel_unpacker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/raw10_pixel_unpacker.sv
// raw10_pixel_unpacker
// Unpacks CSI-2 RAW10 long-packet payload words (4 pixels per 5 bytes) into
// 4-pixel, 10-bit groups tagged with x/y coordinates.
// Optional build macro RAW8_PASSTHROUGH_EN: RAW8 (0x2A) words are also accepted
// and each one emits a group directly with the 2 LSBs of every pixel zeroed.

module raw10_pixel_unpacker #(
  parameter int LINE_WIDTH_BITS   = 16,
  parameter int FRAME_HEIGHT_BITS = 16
) (
  input  logic                         clock_p,
  input  logic                         reset_n,
  input  logic [31:0]                  in_data,
  input  logic                         in_valid,
  input  logic [5:0]                   in_data_type,
  input  logic                         frame_start,
  input  logic                         line_start,
  input  logic                         line_end,
  output logic [39:0]                  pixel_data,
  output logic                         pixel_valid,
  output logic [LINE_WIDTH_BITS-1:0]   x_coord,
  output logic [FRAME_HEIGHT_BITS-1:0] y_coord,
  output logic                         line_error
);

  localparam logic [5:0]                   DT_RAW10 = 6'h2B;
  localparam logic [LINE_WIDTH_BITS-1:0]   X_STEP   = LINE_WIDTH_BITS'(4);
  localparam logic [FRAME_HEIGHT_BITS-1:0] Y_ONE    = FRAME_HEIGHT_BITS'(1);
  localparam logic [FRAME_HEIGHT_BITS-1:0] Y_MAX    = {FRAME_HEIGHT_BITS{1'b1}};

`ifdef RAW8_PASSTHROUGH_EN
  localparam logic [5:0] DT_RAW8 = 6'h2A;

  // RAW8 word to a group: each byte becomes the upper 8 bits of a 10-bit pixel.
  function automatic logic [39:0] raw8_group(input logic [31:0] w);
    logic [39:0] r;
    r = 40'd0;
    for (int k = 0; k < 4; k++) begin
      r[10*k +: 10] = {w[8*k +: 8], 2'b00};
    end
    return r;
  endfunction
`endif

  // Five RAW10 bytes to a group: byte k holds the MSBs of pixel k, byte 4 the LSB pairs.
  function automatic logic [39:0] raw10_group(input logic [39:0] b);
    logic [39:0] r;
    r = 40'd0;
    for (int k = 0; k < 4; k++) begin
      r[10*k +: 10] = {b[8*k +: 8], b[32 + 2*k +: 2]};
    end
    return r;
  endfunction

  // State and registered outputs
  logic [63:0]                  buf_q, buf_d;
  logic [3:0]                   fill_q, fill_d;
  logic [LINE_WIDTH_BITS-1:0]   x_cnt_q, x_cnt_d;
  logic [LINE_WIDTH_BITS-1:0]   x_q, x_d;
  logic [FRAME_HEIGHT_BITS-1:0] y_q, y_d;
  logic [39:0]                  pix_q, pix_d;
  logic                         pv_q, pv_d;
  logic                         err_q, err_d;

  // Decode helpers
  logic        marker_s;
  logic        raw10_acc_s;
  logic        raw8_acc_s;
  logic [63:0] appended_s;
  logic [3:0]  app_fill_s;

  // Classify the incoming word; markers always take priority over data.
  always_comb begin
    marker_s    = frame_start | line_start | line_end;
    raw10_acc_s = in_valid && (in_data_type == DT_RAW10) && !marker_s;
`ifdef RAW8_PASSTHROUGH_EN
    raw8_acc_s  = in_valid && (in_data_type == DT_RAW8) && !marker_s;
`else
    raw8_acc_s  = 1'b0;
`endif
    // Bytes above fill are always zero, so OR-ing in the shifted word appends it.
    appended_s  = buf_q | ({32'd0, in_data} << {fill_q, 3'b000});
    app_fill_s  = fill_q + 4'd4;
  end

  // Next-state computation for the staging buffer, counters and outputs.
  always_comb begin
    buf_d   = buf_q;
    fill_d  = fill_q;
    x_cnt_d = x_cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    pix_d   = pix_q;
    pv_d    = 1'b0;
    err_d   = 1'b0;
    if (marker_s) begin
      buf_d   = 64'd0;
      fill_d  = 4'd0;
      x_cnt_d = '0;
      x_d     = '0;
      // Only line markers report discarded bytes; frame_start drops them silently.
      if ((line_start || line_end) && (fill_q != 4'd0)) begin
        err_d = 1'b1;
      end else begin
        err_d = 1'b0;
      end
      if (frame_start) begin
        y_d = '0;
      end else if (line_end && (y_q != Y_MAX)) begin
        y_d = y_q + Y_ONE;
      end else begin
        y_d = y_q;
      end
    end else if (raw10_acc_s) begin
      if (app_fill_s >= 4'd5) begin
        pix_d   = raw10_group(appended_s[39:0]);
        pv_d    = 1'b1;
        x_d     = x_cnt_q;
        x_cnt_d = x_cnt_q + X_STEP;
        buf_d   = appended_s >> 7'd40;
        fill_d  = app_fill_s - 4'd5;
      end else begin
        buf_d   = appended_s;
        fill_d  = app_fill_s;
      end
    end else if (raw8_acc_s) begin
`ifdef RAW8_PASSTHROUGH_EN
      pix_d   = raw8_group(in_data);
`else
      pix_d   = pix_q;
`endif
      pv_d    = 1'b1;
      x_d     = x_cnt_q;
      x_cnt_d = x_cnt_q + X_STEP;
      buf_d   = 64'd0;
      fill_d  = 4'd0;
      err_d   = (fill_q != 4'd0);
    end else begin
      buf_d  = buf_q;
      fill_d = fill_q;
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clock_p or negedge reset_n) begin
    if (!reset_n) begin
      buf_q   <= 64'd0;
      fill_q  <= 4'd0;
      x_cnt_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pix_q   <= 40'd0;
      pv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      x_cnt_q <= x_cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pix_q   <= pix_d;
      pv_q    <= pv_d;
      err_q   <= err_d;
    end
  end

  assign pixel_data  = pix_q;
  assign pixel_valid = pv_q;
  assign x_coord     = x_q;
  assign y_coord     = y_q;
  assign line_error  = err_q;

endmodule

// File: tb/tb_raw10_pixel_unpacker.sv
// Directed bench for raw10_pixel_unpacker with a byte-queue reference model.
module tb_raw10_pixel_unpacker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic [5:0]  in_data_type = 6'd0;
  logic        frame_start = 1'b0, line_start = 1'b0, line_end = 1'b0;
  logic [39:0] pixel_data;
  logic        pixel_valid;
  logic [15:0] x_coord, y_coord;
  logic        line_error;

  raw10_pixel_unpacker #(.LINE_WIDTH_BITS(16), .FRAME_HEIGHT_BITS(16)) dut (
    .clock_p(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_data_type(in_data_type), .frame_start(frame_start), .line_start(line_start),
    .line_end(line_end), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .x_coord(x_coord), .y_coord(y_coord), .line_error(line_error));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Byte stream 01 02 03 04 E4 repeated four times, as five little-endian words.
  logic [31:0] W [5] = '{32'h04030201, 32'h030201E4, 32'h0201E404, 32'h01E40403, 32'hE4040302};
  // {0x01,00}=0x004, {0x02,01}=0x009, {0x03,10}=0x00E, {0x04,11}=0x013
  localparam logic [39:0] G1 = {10'h013, 10'h00E, 10'h009, 10'h004};
  localparam logic [39:0] G8 = {10'h200, 10'h3FC, 10'h040, 10'h004};

  // Reference model state
  logic [7:0]  mq[$];
  logic [15:0] m_x, m_y;
  logic        nxt_v, nxt_e, exp_v, exp_e;
  logic [39:0] nxt_p, exp_p;
  logic [15:0] nxt_x, exp_x, exp_y;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_x = 16'd0; m_y = 16'd0;
    nxt_v = 1'b0; nxt_e = 1'b0; nxt_p = 40'd0; nxt_x = 16'd0;
    exp_v = 1'b0; exp_e = 1'b0; exp_p = 40'd0; exp_x = 16'd0; exp_y = 16'd0;
  endtask

  // Predict what the outputs show after the coming clock edge.
  task automatic model_update();
    logic [7:0] b[5];
    nxt_v = 1'b0;
    nxt_e = 1'b0;
    if (frame_start || line_start || line_end) begin
      if ((line_start || line_end) && mq.size() > 0) nxt_e = 1'b1;
      mq.delete();
      m_x = 16'd0;
      if (frame_start) m_y = 16'd0;
      else if (line_end && m_y != 16'hFFFF) m_y = m_y + 16'd1;
    end else if (in_valid && in_data_type == 6'h2B) begin
      for (int k = 0; k < 4; k++) mq.push_back(in_data[8*k +: 8]);
      if (mq.size() >= 5) begin
        for (int k = 0; k < 5; k++) b[k] = mq.pop_front();
        for (int k = 0; k < 4; k++)
          nxt_p[10*k +: 10] = 10'(b[k]) * 10'd4 + 10'((b[4] >> (2*k)) % 8'd4);
        nxt_v = 1'b1;
        nxt_x = m_x;
        m_x = m_x + 16'd4;
      end
    end
`ifdef RAW8_PASSTHROUGH_EN
    else if (in_valid && in_data_type == 6'h2A) begin
      if (mq.size() > 0) nxt_e = 1'b1;
      mq.delete();
      for (int k = 0; k < 4; k++) nxt_p[10*k +: 10] = 10'(in_data[8*k +: 8]) * 10'd4;
      nxt_v = 1'b1;
      nxt_x = m_x;
      m_x = m_x + 16'd4;
    end
`endif
  endtask

  task automatic step(input logic [31:0] d, input logic v, input logic [5:0] t,
                      input logic f, input logic l, input logic e);
    in_data = d; in_valid = v; in_data_type = t;
    frame_start = f; line_start = l; line_end = e;
    model_update();
    @(posedge clk);
    exp_v = nxt_v; exp_e = nxt_e; exp_p = nxt_p; exp_x = nxt_x; exp_y = m_y;
    #1;
    in_data = 32'd0; in_valid = 1'b0; in_data_type = 6'd0;
    frame_start = 1'b0; line_start = 1'b0; line_end = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d);
    step(d, 1'b1, 6'h2B, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(32'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en && reset_n) begin
      chk("cmp_valid", 64'(pixel_valid), 64'(exp_v));
      chk("cmp_line_error", 64'(line_error), 64'(exp_e));
      chk("cmp_y", 64'(y_coord), 64'(exp_y));
      if (exp_v) begin
        chk("cmp_pixels", 64'(pixel_data), 64'(exp_p));
        chk("cmp_x", 64'(x_coord), 64'(exp_x));
      end
    end
  end

  initial begin
    model_reset();
    #1;
    chk("reset_valid", 64'(pixel_valid), 64'd0);
    chk("reset_pixels", 64'(pixel_data), 64'd0);
    chk("reset_xy", 64'({x_coord, y_coord}), 64'd0);
    chk("reset_err", 64'(line_error), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cmp_en = 1'b1;

    // 1: one line of RAW10, 5 words -> 4 groups at x 0,4,8,12
    step(32'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    wr(W[0]);
    chk("t1_no_group_first_word", 64'(pixel_valid), 64'd0);
    for (int i = 1; i < 5; i++) begin
      wr(W[i]);
      chk("t1_valid", 64'(pixel_valid), 64'd1);
      chk("t1_pixels", 64'(pixel_data), 64'(G1));
      chk("t1_x", 64'(x_coord), 64'(16'(4*(i-1))));
    end
    idle();
    chk("t1_pulse_ends", 64'(pixel_valid), 64'd0);

    // 2: three words then line_end with 2 bytes left
    wr(W[0]); wr(W[1]); wr(W[2]);
    step(32'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    chk("t2_line_error", 64'(line_error), 64'd1);
    chk("t2_y", 64'(y_coord), 64'd1);
    idle();
    chk("t2_err_one_cycle", 64'(line_error), 64'd0);
    step(32'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    chk("t2_err_clean_start", 64'(line_error), 64'd0);
    wr(W[0]); wr(W[1]);
    chk("t2_new_line_x", 64'(x_coord), 64'd0);

    // 3: two more line_ends, a foreign-type word, then frame_start
    step(32'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    chk("t3_y2", 64'(y_coord), 64'd2);
    step(32'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    chk("t3_y3", 64'(y_coord), 64'd3);
    wr(W[0]);
    step(32'hDEADBEEF, 1'b1, 6'h2C, 1'b0, 1'b0, 1'b0);
    chk("t3_foreign_ignored", 64'(pixel_valid), 64'd0);
    wr(W[1]);
    chk("t3_fill_kept", 64'(pixel_data), 64'(G1));
    step(32'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
    chk("t3_fs_no_err", 64'(line_error), 64'd0);
    chk("t3_fs_y", 64'(y_coord), 64'd0);

    // 4: word coinciding with line_start is dropped
    step(W[0], 1'b1, 6'h2B, 1'b0, 1'b1, 1'b0);
    chk("t4_dropped", 64'(pixel_valid), 64'd0);
    for (int i = 0; i < 5; i++) wr(W[i]);
    chk("t4_last_x", 64'(x_coord), 64'd12);
    chk("t4_last_pixels", 64'(pixel_data), 64'(G1));

    // 5: asynchronous reset with fill=3
    step(32'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    wr(W[0]); wr(W[1]);
    cmp_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_valid", 64'(pixel_valid), 64'd0);
    chk("t5_async_pixels", 64'(pixel_data), 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    wr(W[0]);
    cmp_en = 1'b1;
    wr(W[1]);
    chk("t5_after_reset_x", 64'(x_coord), 64'd0);
    chk("t5_after_reset_pixels", 64'(pixel_data), 64'(G1));
    wr(W[2]); wr(W[3]); wr(W[4]);
    chk("t5_fourth_x", 64'(x_coord), 64'd12);

    // 6: RAW8 word
    step(32'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    step(32'h80FF1001, 1'b1, 6'h2A, 1'b0, 1'b0, 1'b0);
`ifdef RAW8_PASSTHROUGH_EN
    chk("t6_raw8_valid", 64'(pixel_valid), 64'd1);
    chk("t6_raw8_pixels", 64'(pixel_data), 64'(G8));
    chk("t6_raw8_x", 64'(x_coord), 64'd0);
`else
    chk("t6_raw8_ignored", 64'(pixel_valid), 64'd0);
`endif
    wr(W[0]);
    step(32'h80FF1001, 1'b1, 6'h2A, 1'b0, 1'b0, 1'b0);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
